melody_sequencer: RTL and testbench

Controller that sequences the note generator for the audio demo. Plays a fixed 16-step melody at a fixed tempo, lets the three manual note keys override playback, and owns the volume level that sets the generator's amplitude bounds. Sits between the debounced/one-pulsed button logic and the note generator. Its `note_div`, `audio_max` and `audio_min` outputs connect directly to the generator; `vol_level` drives the two-digit display.

---
 rtl/audio_pkg.sv | 39 +++
 rtl/volume_ctrl.sv | 58 +++++
 rtl/melody_sequencer.sv | 121 ++++++++++++
 tb/tb_melody_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/audio_pkg.sv
// Shared types and constants for the audio demo: note codes, note dividers,
// the fixed melody, the sequencer state encoding and the amplitude midpoint.
package audio_pkg;

    typedef enum logic [1:0] {
        REST = 2'd0,
        DO   = 2'd1,
        RE   = 2'd2,
        MI   = 2'd3
    } note_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PLAY  = 2'd1,
        S_PAUSE = 2'd2
    } state_t;

    localparam logic [21:0] DIV_DO   = 22'd191571;
    localparam logic [21:0] DIV_RE   = 22'd170648;
    localparam logic [21:0] DIV_MI   = 22'd151515;
    localparam logic [21:0] DIV_REST = 22'd0;

    localparam logic [15:0] MIDPOINT = 16'h8000;

    localparam note_t MELODY [16] = '{
        MI, RE, DO, RE, MI, MI, MI, REST,
        RE, RE, RE, REST, MI, MI, MI, REST
    };

    function automatic logic [21:0] note_div_of(input note_t n);
        case (n)
            DO:      return DIV_DO;
            RE:      return DIV_RE;
            MI:      return DIV_MI;
            default: return DIV_REST;
        endcase
    endfunction

endpackage

// File: rtl/volume_ctrl.sv
// Saturating 0..15 volume level and the offset-binary amplitude bounds it
// implies; the bounds register together with the level.
module volume_ctrl
    import audio_pkg::*;
#(
    parameter int VOL_STEP = 1280
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        vol_up_pulse,
    input  logic        vol_down_pulse,
    output logic [3:0]  vol_level,
    output logic [15:0] audio_max,
    output logic [15:0] audio_min
);

    localparam logic [3:0] LEVEL_RESET = 4'd15;

    function automatic logic [3:0] sat_inc(input logic [3:0] lvl);
        return (lvl == 4'd15) ? lvl : lvl + 4'd1;
    endfunction

    function automatic logic [3:0] sat_dec(input logic [3:0] lvl);
        return (lvl == 4'd0) ? lvl : lvl - 4'd1;
    endfunction

    function automatic logic [15:0] amp_of(input logic [3:0] lvl);
        return 16'(lvl) * 16'(VOL_STEP);
    endfunction

    logic [3:0]  level_p0;
    logic [15:0] amp_p0;

    // stage p0: next level and its amplitude
    always_comb begin
        level_p0 = vol_level;
        case ({vol_up_pulse, vol_down_pulse})
            2'b10:   level_p0 = sat_inc(vol_level);
            2'b01:   level_p0 = sat_dec(vol_level);
            default: level_p0 = vol_level;
        endcase
        amp_p0 = amp_of(level_p0);
    end

    // stage p1: registered level and bounds
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vol_level <= LEVEL_RESET;
            audio_max <= MIDPOINT + amp_of(LEVEL_RESET);
            audio_min <= MIDPOINT - amp_of(LEVEL_RESET);
        end else begin
            vol_level <= level_p0;
            audio_max <= MIDPOINT + amp_p0;
            audio_min <= MIDPOINT - amp_p0;
        end
    end

endmodule

// File: rtl/melody_sequencer.sv
// Melody sequencer: IDLE/PLAY/PAUSE control, beat counter, note mux with key
// override, and volume. Define MELODY_LOOP_EN to loop the melody forever.
module melody_sequencer
    import audio_pkg::*;
#(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int VOL_STEP    = 1280
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_pulse,
    input  logic        stop_pulse,
    input  logic        key_do,
    input  logic        key_re,
    input  logic        key_mi,
    input  logic        vol_up_pulse,
    input  logic        vol_down_pulse,
    output logic [21:0] note_div,
    output logic [15:0] audio_max,
    output logic [15:0] audio_min,
    output logic [3:0]  vol_level,
    output logic [3:0]  step_idx,
    output logic        playing
);

    localparam int              CNT_W    = $clog2(BEAT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BEAT_CYCLES - 1);

    state_t           state_p0, state_p1;
    logic [CNT_W-1:0] cnt_p0, cnt_p1;
    logic [3:0]       step_p0;
    logic [21:0]      div_p0;
    logic             any_key;

    assign any_key = key_do | key_re | key_mi;

    // stage p0: next state, counter, step and note divider
    always_comb begin
        state_p0 = state_p1;
        cnt_p0   = cnt_p1;
        step_p0  = step_idx;
        if (stop_pulse) begin
            state_p0 = S_IDLE;
            cnt_p0   = '0;
            step_p0  = 4'd0;
        end else begin
            case (state_p1)
                S_IDLE: begin
                    if (play_pulse) begin
                        state_p0 = S_PLAY;
                        cnt_p0   = '0;
                        step_p0  = 4'd0;
                    end
                end
                S_PLAY: begin
                    if (play_pulse) begin
                        state_p0 = S_PAUSE;
                    end else if (!any_key) begin
                        if (cnt_p1 == CNT_LAST) begin
                            cnt_p0 = '0;
                            if (step_idx == 4'd15) begin
                                step_p0 = 4'd0;
`ifndef MELODY_LOOP_EN
                                state_p0 = S_IDLE;
`endif
                            end else begin
                                step_p0 = step_idx + 4'd1;
                            end
                        end else begin
                            cnt_p0 = cnt_p1 + 1'b1;
                        end
                    end
                end
                S_PAUSE: begin
                    if (play_pulse) state_p0 = S_PLAY;
                end
                default: begin
                    state_p0 = S_IDLE;
                    cnt_p0   = '0;
                    step_p0  = 4'd0;
                end
            endcase
        end

        if (key_do)                div_p0 = DIV_DO;
        else if (key_re)           div_p0 = DIV_RE;
        else if (key_mi)           div_p0 = DIV_MI;
        else if (state_p0 == S_PLAY) div_p0 = note_div_of(MELODY[step_p0]);
        else                       div_p0 = DIV_REST;
    end

    // stage p1: registered control and outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_p1 <= S_IDLE;
            cnt_p1   <= '0;
            step_idx <= 4'd0;
            note_div <= '0;
            playing  <= 1'b0;
        end else begin
            state_p1 <= state_p0;
            cnt_p1   <= cnt_p0;
            step_idx <= step_p0;
            note_div <= div_p0;
            playing  <= (state_p0 == S_PLAY);
        end
    end

    volume_ctrl #(
        .VOL_STEP(VOL_STEP)
    ) u_volume_ctrl (
        .clk           (clk),
        .rst           (rst),
        .vol_up_pulse  (vol_up_pulse),
        .vol_down_pulse(vol_down_pulse),
        .vol_level     (vol_level),
        .audio_max     (audio_max),
        .audio_min     (audio_min)
    );

endmodule

// File: tb/tb_melody_sequencer.sv
// Directed scoreboard bench for melody_sequencer with BEAT_CYCLES=4; honours
// MELODY_LOOP_EN for the end-of-melody expectation.
module tb_melody_sequencer;

    localparam logic [31:0] D_DO = 32'd191571;
    localparam logic [31:0] D_RE = 32'd170648;
    localparam logic [31:0] D_MI = 32'd151515;

    localparam int SIG_NOTE = 0;
    localparam int SIG_VOL  = 1;
    localparam int SIG_MAX  = 2;
    localparam int SIG_MIN  = 3;
    localparam int SIG_STEP = 4;
    localparam int SIG_PLAY = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        play_pulse = 1'b0;
    logic        stop_pulse = 1'b0;
    logic        key_do = 1'b0;
    logic        key_re = 1'b0;
    logic        key_mi = 1'b0;
    logic        vol_up_pulse = 1'b0;
    logic        vol_down_pulse = 1'b0;
    logic [21:0] note_div;
    logic [15:0] audio_max;
    logic [15:0] audio_min;
    logic [3:0]  vol_level;
    logic [3:0]  step_idx;
    logic        playing;

    typedef struct {
        string       tag;
        int          sig;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    logic [31:0] mel_div [16] = '{
        D_MI, D_RE, D_DO, D_RE, D_MI, D_MI, D_MI, 32'd0,
        D_RE, D_RE, D_RE, 32'd0, D_MI, D_MI, D_MI, 32'd0
    };

    melody_sequencer #(
        .BEAT_CYCLES(4),
        .VOL_STEP   (1280)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .play_pulse    (play_pulse),
        .stop_pulse    (stop_pulse),
        .key_do        (key_do),
        .key_re        (key_re),
        .key_mi        (key_mi),
        .vol_up_pulse  (vol_up_pulse),
        .vol_down_pulse(vol_down_pulse),
        .note_div      (note_div),
        .audio_max     (audio_max),
        .audio_min     (audio_min),
        .vol_level     (vol_level),
        .step_idx      (step_idx),
        .playing       (playing)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] sample(input int sig);
        case (sig)
            SIG_NOTE: return 32'(note_div);
            SIG_VOL:  return 32'(vol_level);
            SIG_MAX:  return 32'(audio_max);
            SIG_MIN:  return 32'(audio_min);
            SIG_STEP: return 32'(step_idx);
            default:  return 32'(playing);
        endcase
    endfunction

    task automatic push(input string tag, input int sig, input logic [31:0] v);
        exp_t e;
        e.tag = tag;
        e.sig = sig;
        e.exp = v;
        sb.push_back(e);
    endtask

    task automatic drain();
        exp_t        e;
        logic [31:0] obs;
        while (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = sample(e.sig);
            checks++;
            assert (obs === e.exp) else begin
                errors++;
                $error("FAIL %s observed=%0d expected=%0d", e.tag, obs, e.exp);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        drain();
    endtask

    task automatic push_vol(input string tag, input int lvl);
        push(tag, SIG_VOL, 32'(lvl));
        push(tag, SIG_MAX, 32'(16'h8000 + 16'(lvl * 1280)));
        push(tag, SIG_MIN, 32'(16'h8000 - 16'(lvl * 1280)));
    endtask

    initial begin
        // reset values, both during and after reset
        repeat (2) @(posedge clk);
        #1;
        push("rst_note", SIG_NOTE, 0);
        push_vol("rst_vol", 15);
        push("rst_max_const", SIG_MAX, 32'h0000CB00);
        push("rst_min_const", SIG_MIN, 32'h00003500);
        push("rst_play", SIG_PLAY, 0);
        push("rst_step", SIG_STEP, 0);
        drain();
        rst = 1'b0;
        push("idle_note", SIG_NOTE, 0);
        push("idle_play", SIG_PLAY, 0);
        tick();

        // start playback: MI x4, RE x4, then DO
        play_pulse = 1'b1;
        for (int i = 0; i < 8; i++) begin
            push("seq_note", SIG_NOTE, (i < 4) ? D_MI : D_RE);
            push("seq_step", SIG_STEP, (i < 4) ? 0 : 1);
            push("seq_play", SIG_PLAY, 1);
            tick();
            play_pulse = 1'b0;
        end
        push("seq_do", SIG_NOTE, D_DO);
        push("seq_do_step", SIG_STEP, 2);
        tick();
        push("seq_do2", SIG_NOTE, D_DO);
        tick();

        // pause during step 2, resume 10 cycles later
        play_pulse = 1'b1;
        push("pause_note", SIG_NOTE, 0);
        push("pause_play", SIG_PLAY, 0);
        push("pause_step", SIG_STEP, 2);
        tick();
        play_pulse = 1'b0;
        for (int i = 0; i < 9; i++) begin
            push("paused_note", SIG_NOTE, 0);
            tick();
        end
        play_pulse = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push("resume_note", SIG_NOTE, D_DO);
            push("resume_step", SIG_STEP, 2);
            push("resume_play", SIG_PLAY, 1);
            tick();
            play_pulse = 1'b0;
        end
        push("resume_next", SIG_NOTE, D_RE);
        push("resume_next_step", SIG_STEP, 3);
        tick();

        // stop, restart, hold key_do for 6 cycles in step 0
        stop_pulse = 1'b1;
        push("stop_note", SIG_NOTE, 0);
        push("stop_step", SIG_STEP, 0);
        push("stop_play", SIG_PLAY, 0);
        tick();
        stop_pulse = 1'b0;
        play_pulse = 1'b1;
        push("key_pre", SIG_NOTE, D_MI);
        tick();
        play_pulse = 1'b0;
        push("key_pre2", SIG_NOTE, D_MI);
        tick();
        key_do = 1'b1;
        for (int i = 0; i < 6; i++) begin
            push("key_do_note", SIG_NOTE, D_DO);
            push("key_do_step", SIG_STEP, 0);
            push("key_do_play", SIG_PLAY, 1);
            tick();
        end
        key_do = 1'b0;
        for (int i = 0; i < 2; i++) begin
            push("key_rel_note", SIG_NOTE, D_MI);
            push("key_rel_step", SIG_STEP, 0);
            tick();
        end
        push("key_rel_next", SIG_NOTE, D_RE);
        push("key_rel_next_step", SIG_STEP, 1);
        tick();

        // stop beats a simultaneous play, in PLAY and in IDLE
        stop_pulse = 1'b1;
        play_pulse = 1'b1;
        push("stop_win_play", SIG_PLAY, 0);
        push("stop_win_note", SIG_NOTE, 0);
        push("stop_win_step", SIG_STEP, 0);
        tick();
        push("stop_win_idle", SIG_PLAY, 0);
        tick();
        stop_pulse = 1'b0;
        play_pulse = 1'b0;

        // key priority while idle
        key_mi = 1'b1;
        push("idle_key_mi", SIG_NOTE, D_MI);
        tick();
        key_re = 1'b1;
        push("idle_key_re_mi", SIG_NOTE, D_RE);
        tick();
        key_do = 1'b1;
        push("idle_key_all", SIG_NOTE, D_DO);
        push("idle_key_play", SIG_PLAY, 0);
        tick();
        key_do = 1'b0;
        key_re = 1'b0;
        key_mi = 1'b0;
        push("idle_key_off", SIG_NOTE, 0);
        tick();

        // volume saturation both ways
        vol_up_pulse = 1'b1;
        for (int i = 0; i < 20; i++) begin
            push_vol("vol_up_sat", 15);
            tick();
        end
        vol_up_pulse = 1'b0;
        vol_down_pulse = 1'b1;
        for (int i = 1; i <= 17; i++) begin
            push_vol("vol_down", (i > 15) ? 0 : 15 - i);
            tick();
        end
        vol_down_pulse = 1'b0;
        push("vol_zero_max", SIG_MAX, 32'h00008000);
        push("vol_zero_min", SIG_MIN, 32'h00008000);
        tick();
        vol_up_pulse = 1'b1;
        push_vol("vol_up_one", 1);
        tick();
        vol_down_pulse = 1'b1;
        push_vol("vol_both", 1);
        tick();
        vol_up_pulse = 1'b0;
        vol_down_pulse = 1'b0;

        // full melody: 64 cycles of unkeyed PLAY
        play_pulse = 1'b1;
        for (int c = 0; c < 64; c++) begin
            if (c % 4 == 0) begin
                push("mel_note", SIG_NOTE, mel_div[c / 4]);
                push("mel_step", SIG_STEP, 32'(c / 4));
                push("mel_play", SIG_PLAY, 1);
            end
            tick();
            play_pulse = 1'b0;
        end
`ifdef MELODY_LOOP_EN
        push("end_step", SIG_STEP, 0);
        push("end_play", SIG_PLAY, 1);
        push("end_note", SIG_NOTE, D_MI);
`else
        push("end_step", SIG_STEP, 0);
        push("end_play", SIG_PLAY, 0);
        push("end_note", SIG_NOTE, 0);
`endif
        tick();
        stop_pulse = 1'b1;
        push("end_stop", SIG_PLAY, 0);
        tick();
        stop_pulse = 1'b0;

        // asynchronous reset in the middle of the melody
        play_pulse = 1'b1;
        tick();
        play_pulse = 1'b0;
        repeat (5) tick();
        push("mid_pre_step", SIG_STEP, 1);
        drain();
        #1;
        rst = 1'b1;
        #1;
        push("arst_note", SIG_NOTE, 0);
        push("arst_step", SIG_STEP, 0);
        push("arst_play", SIG_PLAY, 0);
        push_vol("arst_vol", 15);
        drain();
        @(posedge clk);
        #1;
        rst = 1'b0;
        push("post_arst_play", SIG_PLAY, 0);
        push("post_arst_note", SIG_NOTE, 0);
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
